// File: rtl/edge_arb_pkg.sv
// ----------------------------------------------------------------------------
// edge_arb_pkg
//   Shared types, defaults and the round-robin search helper used by the
//   edge_event_arbiter slice (edge_det_ch + edge_event_arbiter).
//
//   Contents:
//     edge_t      - polarity of a captured edge (EDGE_FALL / EDGE_RISE)
//     DEF_NUM_CH  - default channel count
//     DEF_TS_W    - default timestamp width (EDGE_ARB_TIMESTAMP_EN builds)
//     RR_MAX_CH   - widest request vector the search helper handles
//     rr_next()   - first requester after 'last', with wrap-around
// ----------------------------------------------------------------------------
package edge_arb_pkg;

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_TS_W   = 16;
    localparam int RR_MAX_CH  = 16;

    // Returns {found, index}. The search starts one past 'last' and wraps
    // modulo n, so the most recently served channel has lowest priority.
    function automatic logic [4:0] rr_next(
        input logic [RR_MAX_CH-1:0] req,
        input logic [3:0]           last,
        input int unsigned          n
    );
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int unsigned off = 1; off <= n; off++) begin
            idx = 4'((32'(last) + off) % n);
            if (!res[4] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// ----------------------------------------------------------------------------
// edge_det_ch
//   Per-channel edge detector with a single-entry pending slot and a sticky
//   overflow flag. One instance per monitored line.
//
//   Ports:
//     clk       in   system clock, rising edge
//     i_rst_n   in   asynchronous active-low reset
//     i_d       in   monitored line (synchronous to clk)
//     i_en      in   capture enable; edges are ignored when 0
//     i_primed  in   0 on the first cycle after reset (suppresses detection)
//     i_grant   in   pending event is being taken by the arbiter this cycle
//     i_clr     in   clear pulse for the sticky overflow flag
//     i_ts      in   timestamp counter        (EDGE_ARB_TIMESTAMP_EN only)
//     o_pend    out  an event is pending
//     o_rise    out  polarity of the pending event (1 = rising)
//     o_ovf     out  sticky overflow flag
//     o_ts      out  timestamp of the pending event (EDGE_ARB_TIMESTAMP_EN only)
//
//   Optional feature macro: EDGE_ARB_TIMESTAMP_EN
// ----------------------------------------------------------------------------
module edge_det_ch
    import edge_arb_pkg::*;
`ifdef EDGE_ARB_TIMESTAMP_EN
#(
    parameter int TS_W = DEF_TS_W
)
`endif
(
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_d,
    input  logic            i_en,
    input  logic            i_primed,
    input  logic            i_grant,
    input  logic            i_clr,
`ifdef EDGE_ARB_TIMESTAMP_EN
    input  logic [TS_W-1:0] i_ts,
    output logic [TS_W-1:0] o_ts,
`endif
    output logic            o_pend,
    output logic            o_rise,
    output logic            o_ovf
);

    logic  r_prev;
    logic  r_pend;
    edge_t r_ptype;
    logic  r_ovf;

    logic  w_edge;
    logic  w_drop;
    logic  w_capture;

    // prev tracks the line unconditionally, so re-enabling a channel never
    // reports a transition that happened while it was disabled.
    assign w_edge    = i_primed & i_en & (i_d ^ r_prev);
    // A slot that is being granted this cycle is free for the new edge.
    assign w_drop    = w_edge & r_pend & ~i_grant;
    assign w_capture = w_edge & ~w_drop;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_pend  <= 1'b0;
            r_ptype <= EDGE_FALL;
            r_ovf   <= 1'b0;
        end else begin
            r_prev <= i_d;

            if (w_capture) begin
                r_pend  <= 1'b1;
                r_ptype <= i_d ? EDGE_RISE : EDGE_FALL;
            end else if (i_grant) begin
                r_pend  <= 1'b0;
            end

            // Set has priority over a coincident clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ts <= '0;
        end else if (w_capture) begin
            r_ts <= i_ts;
        end
    end

    assign o_ts = r_ts;
`endif

    assign o_pend = r_pend;
    assign o_rise = (r_ptype == EDGE_RISE);
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// ----------------------------------------------------------------------------
// edge_event_arbiter
//   Detects rising/falling edges on NUM_CH synchronous lines, keeps at most
//   one pending event per channel and hands them one at a time to a single
//   consumer over valid/ready, using round-robin arbitration.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     d_in       in   monitored lines [NUM_CH]
//     ch_en      in   per-channel detect enable [NUM_CH]
//     evt_valid  out  event presented to the consumer
//     evt_ready  in   consumer accepts the presented event
//     evt_ch     out  channel index of the presented event [CH_W]
//     evt_rise   out  1 = rising edge, 0 = falling edge
//     evt_ts     out  capture timestamp [TS_W] (EDGE_ARB_TIMESTAMP_EN only)
//     ovf        out  sticky per-channel overflow flags [NUM_CH]
//     ovf_clr    in   per-channel overflow clear pulse [NUM_CH]
//
//   Optional feature macro: EDGE_ARB_TIMESTAMP_EN
//     Adds parameter TS_W, a free-running timestamp counter, per-channel
//     timestamp storage and the evt_ts output.
// ----------------------------------------------------------------------------
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
`ifdef EDGE_ARB_TIMESTAMP_EN
   ,parameter int TS_W   = DEF_TS_W
`endif
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] d_in,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
`ifdef EDGE_ARB_TIMESTAMP_EN
    output logic [TS_W-1:0]   evt_ts,
`endif
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_primed;
    logic [CH_W-1:0]   r_rr;
    logic              r_evt_valid;
    logic [CH_W-1:0]   r_evt_ch;
    logic              r_evt_rise;

    // ------------------------------------------------------------------
    // Channel interface
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_grant;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                 w_load;
    logic [RR_MAX_CH-1:0] w_req;
    logic [3:0]           w_last;
    logic [4:0]           w_pick;
    logic                 w_found;
    logic [CH_W-1:0]      w_idx;
    logic                 w_sel_rise;

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0]   r_ts_cnt;
    logic [TS_W-1:0]   r_evt_ts;
    logic [TS_W-1:0]   w_ts [NUM_CH];
    logic [TS_W-1:0]   w_sel_ts;
`endif

    // The output register takes a new event whenever it is empty or the
    // presented one is being accepted; otherwise it holds steady.
    assign w_load = ~r_evt_valid | evt_ready;

    always_comb begin
        w_req                = '0;
        w_req[NUM_CH-1:0]    = w_pend;
        w_last               = '0;
        w_last[CH_W-1:0]     = r_rr;
        w_pick               = rr_next(w_req, w_last, NUM_CH);
        w_found              = w_pick[4] & w_load;
        w_grant              = '0;
        w_idx                = '0;
        w_sel_rise           = 1'b0;
`ifdef EDGE_ARB_TIMESTAMP_EN
        w_sel_ts             = '0;
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_found && (w_pick[3:0] == 4'(i))) begin
                w_grant[i] = 1'b1;
                w_idx      = CH_W'(i);
                w_sel_rise = w_rise[i];
`ifdef EDGE_ARB_TIMESTAMP_EN
                w_sel_ts   = w_ts[i];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel detectors
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_det_ch
`ifdef EDGE_ARB_TIMESTAMP_EN
        #(
            .TS_W     (TS_W)
        )
`endif
        u_ch (
            .clk      (clk),
            .i_rst_n  (rst),
            .i_d      (d_in[g]),
            .i_en     (ch_en[g]),
            .i_primed (r_primed),
            .i_grant  (w_grant[g]),
            .i_clr    (ovf_clr[g]),
`ifdef EDGE_ARB_TIMESTAMP_EN
            .i_ts     (r_ts_cnt),
            .o_ts     (w_ts[g]),
`endif
            .o_pend   (w_pend[g]),
            .o_rise   (w_rise[g]),
            .o_ovf    (w_ovf[g])
        );
    end

    // ------------------------------------------------------------------
    // Priming: the first edge after reset only loads prev in the channels.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_primed <= 1'b0;
        end else begin
            r_primed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
            // Starting at NUM_CH-1 makes channel 0 the first winner.
            r_rr        <= CH_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_found) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_idx;
                r_evt_rise  <= w_sel_rise;
                r_rr        <= w_idx;
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

`ifdef EDGE_ARB_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_ts <= '0;
        end else if (w_found) begin
            r_evt_ts <= w_sel_ts;
        end
    end

    assign evt_ts = r_evt_ts;
`endif

    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign evt_rise  = r_evt_rise;
    assign ovf       = w_ovf;

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Watches NUM_CH synchronous input lines and detects rising and falling edges on each one.
- Holds at most one pending edge event per channel.
- Shares a single downstream event consumer between channels using round-robin arbitration over a valid/ready handshake.
- Sits between the per-signal edge logic and the core's event/interrupt sink; software configures it through per-channel enables and sticky overflow flags.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- CH_W, $clog2(NUM_CH), width of the channel index output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- d_in  input  NUM_CH  monitored lines, already synchronous to clk.
- ch_en  input  NUM_CH  per-channel detect enable; 0 = edges ignored.
- evt_valid  output  1  event presented to consumer.
- evt_ready  input  1  consumer accepts event.
- evt_ch  output  CH_W  channel index of presented event.
- evt_rise  output  1  1 = rising edge, 0 = falling edge.
- ovf  output  NUM_CH  sticky per-channel overflow flags.
- ovf_clr  input  NUM_CH  per-channel overflow clear pulse.

Behaviour:
- Reset (rst=0, async): evt_valid=0, evt_ch=0, evt_rise=0, ovf=0, all pend=0, rr pointer=NUM_CH-1, prev=0, primed=0.
- Priming: on the first clk edge after rst deasserts, prev<=d_in, primed<=1, and no edges are detected. This means a line held high through reset produces no spurious rise.
- Detection (primed=1): rise[i]=d_in[i]&~prev[i]; fall[i]=~d_in[i]&prev[i]. prev updates every cycle regardless of ch_en.
- Capture: an edge on a channel with ch_en[i]=1 sets pend[i]=1 and ptype[i]=rise at that clk edge.
  - If pend[i] is already 1 and is not being granted that cycle, the new edge is dropped and ovf[i]<=1.
  - If pend[i] is granted in the same cycle, the new edge is captured and ovf is unchanged.
- Output register: it loads when evt_valid=0 or (evt_valid&evt_ready).
  - The grant goes to the first channel with pend=1 searching from rr+1 upward, with wrap-around.
  - On grant: evt_valid<=1, evt_ch<=i, evt_rise<=ptype[i], pend[i]<=0, rr<=i.
  - If nothing is pending: evt_valid<=0.
- Stability: while evt_valid&~evt_ready, evt_ch and evt_rise hold and no grant occurs.
- Latency: a d_in transition sampled at clk edge E sets pend at E. With the output idle, evt_valid=1 after E+1. Back-to-back accepts sustain one event per cycle.
- Fairness: with all channels pending continuously, grants rotate 0,1,..,NUM_CH-1,0.
- ch_en deassert: blocks new captures only. An event already pending or presented still completes.
- ovf: a set and ovf_clr on the same channel in the same cycle leaves ovf=1 (set wins).
- Events are not cancellable; a rst assertion mid-operation discards all pending and presented events.

Optional Feature:
- Macro: EDGE_ARB_TIMESTAMP_EN.
- Defined: adds parameter TS_W (default 16) and output evt_ts [TS_W-1:0].
  - A free-running counter resets to 0 and wraps at 2^TS_W.
  - Each channel stores the counter value at capture.
  - evt_ts loads alongside evt_ch and follows the same hold rules; it resets to 0.
- Undefined: no counter, no storage, no evt_ts port. All other behaviour is identical.

Decomposition:
- Package edge_arb_pkg:
  - enum edge_t {EDGE_FALL=0, EDGE_RISE=1};
  - localparam DEF_NUM_CH=4;
  - localparam DEF_TS_W=16;
  - function for round-robin next index.
- Sub-module edge_det_ch, one instance per channel, generated. It holds prev, pend, ptype, ovf (and ts when the macro is defined), and takes grant/clr inputs.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset with d_in=4'b0101, release rst, hold d_in steady 5 cycles -> evt_valid stays 0 and ovf=0 (priming suppresses edges).
- ch_en=4'hF, evt_ready=1, d_in[2] 0->1 -> one event: evt_ch=2, evt_rise=1, evt_valid high for exactly 1 cycle, 1 cycle after pend sets.
- evt_ready=0, d_in all rise at once, then evt_ready=1 -> evt_ch sequence 0,1,2,3 on consecutive cycles with evt_rise=1, no ovf.
- evt_ready=0, d_in[1] rise then fall while pending -> ovf[1]=1; on ready only the rise is delivered. Then assert ovf_clr[1] -> ovf[1]=0. Same-cycle set and clr -> ovf[1] stays 1.
- ch_en[3]=0, toggle d_in[3] -> no events. Presented event held stable over 4 cycles of evt_ready=0 while other channels toggle.
- Assert rst mid-stream with 3 events pending -> all outputs are reset values immediately (async), and no stale events after release.
